// File: rtl/config_read_initiator.sv
// AXI-Lite read-channel front end: turns one AR request at a time into a
// read_config request, waits for the config response and returns it on R.
module config_read_initiator #(
    parameter int ADDR_BITS      = 16,
    parameter int DATA_BITS      = 64,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_BITS-1:0] s_axil_araddr,
    input  logic                 s_axil_arvalid,
    output logic                 s_axil_arready,
    output logic [DATA_BITS-1:0] s_axil_rdata,
    output logic [1:0]           s_axil_rresp,
    output logic                 s_axil_rvalid,
    input  logic                 s_axil_rready,
    output logic                 conf_read_valid,
    input  logic                 conf_read_ready,
    output logic [ADDR_BITS-1:0] conf_read_addr,
    input  logic                 conf_resp_valid,
    output logic                 conf_resp_ready,
    input  logic [DATA_BITS-1:0] conf_resp_data,
    input  logic                 conf_resp_error
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    // With the timeout disabled this evaluates to all ones and is never used for expiry.
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REQ       = 2'd1,
        WAIT_RESP = 2'd2,
        RESP      = 2'd3
    } state_t;

    state_t               state_reg, state_next;
    logic [ADDR_BITS-1:0] addr_reg, addr_next;
    logic [DATA_BITS-1:0] rdata_reg, rdata_next;
    logic [1:0]           rresp_reg, rresp_next;
    logic [CNT_W-1:0]     cnt_reg, cnt_next;
    logic [CNT_W-1:0]     cnt_inc;
    logic                 expired;

    assign cnt_inc = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + 1'b1;
    assign expired = (TIMEOUT_CYCLES != 0) && (cnt_reg == CNT_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            addr_reg  <= '0;
            rdata_reg <= '0;
            rresp_reg <= RESP_OKAY;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
            rdata_reg <= rdata_next;
            rresp_reg <= rresp_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        rdata_next = rdata_reg;
        rresp_next = rresp_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (s_axil_arvalid) begin
                    addr_next  = s_axil_araddr;
                    cnt_next   = '0;
                    state_next = REQ;
                end
            end
            REQ: begin
                cnt_next = cnt_inc;
                // A handshake in the expiry cycle takes priority over the abort.
                if (conf_read_ready) begin
                    state_next = WAIT_RESP;
                end else if (expired) begin
                    rdata_next = '0;
                    rresp_next = RESP_SLVERR;
                    state_next = RESP;
                end
            end
            WAIT_RESP: begin
                cnt_next = cnt_inc;
                if (conf_resp_valid) begin
                    rdata_next = conf_resp_data;
                    rresp_next = conf_resp_error ? RESP_DECERR : RESP_OKAY;
                    state_next = RESP;
                end else if (expired) begin
                    rdata_next = '0;
                    rresp_next = RESP_SLVERR;
                    state_next = RESP;
                end
            end
            RESP: begin
                if (s_axil_rready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs decode straight from state; responses in IDLE are sunk.
    assign s_axil_arready  = (state_reg == IDLE);
    assign s_axil_rvalid   = (state_reg == RESP);
    assign s_axil_rdata    = rdata_reg;
    assign s_axil_rresp    = rresp_reg;
    assign conf_read_valid = (state_reg == REQ);
    assign conf_read_addr  = addr_reg;
    assign conf_resp_ready = (state_reg == IDLE) || (state_reg == WAIT_RESP);

endmodule
